// File: rtl/mult_arbiter_if.sv
// Bus bundle for mult_arbiter: requester ports, response port and multiplier port.
// slave = arbiter side, master = environment side.
interface mult_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;

  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  resp_err;
  logic                  resp_ready;

  logic                  mult_ld;
  logic [WIDTH-1:0]      mult_a;
  logic [WIDTH-1:0]      mult_b;
  logic                  mult_ready;
  logic                  mult_done;
  logic [2*WIDTH-1:0]    mult_product;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mult_ready, mult_done, mult_product,
    output req_ready, resp_valid, resp_id, resp_product, resp_err, mult_ld, mult_a, mult_b
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mult_ready, mult_done, mult_product,
    input  req_ready, resp_valid, resp_id, resp_product, resp_err, mult_ld, mult_a, mult_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier among NREQ requesters,
// with a BUSY-cycle watchdog that returns an error response on timeout.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 2*WIDTH+4
) (
  input  logic           clk,
  input  logic           reset,
  mult_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_RESP} state_t;

  state_t             r_state, w_next;
  logic [IDW-1:0]     r_last, r_id;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_err;

  logic               w_found, w_grant, w_tmo;
  logic [IDW-1:0]     w_gnt_id;
  logic [WIDTH-1:0]   w_sel_a, w_sel_b;

  // First pass takes indices above last_grant, second pass wraps to the rest.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++)
      if (!w_found && bus.req_valid[i] && i > int'(r_last)) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'(i);
        w_sel_a  = bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b  = bus.req_b[i*WIDTH +: WIDTH];
      end
    for (int i = 0; i < NREQ; i++)
      if (!w_found && bus.req_valid[i] && i <= int'(r_last)) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'(i);
        w_sel_a  = bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b  = bus.req_b[i*WIDTH +: WIDTH];
      end
  end

  assign w_grant = (r_state == S_IDLE) && w_found && bus.mult_ready && !reset;
  assign w_tmo   = (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_next = S_LOAD;
      S_LOAD: w_next = S_BUSY;
      S_BUSY: if (bus.mult_done || w_tmo) w_next = S_RESP;
      S_RESP: if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = w_grant ? (NREQ'(1) << w_gnt_id) : '0;
    bus.mult_ld    = (r_state == S_LOAD);
    bus.resp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= IDW'(NREQ-1);
      r_id   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last <= w_gnt_id;
        r_id   <= w_gnt_id;
        r_a    <= w_sel_a;
        r_b    <= w_sel_b;
      end
      case (r_state)
        S_LOAD: r_cnt <= CW'(1);
        S_BUSY: begin
          // A completion in the timeout cycle still counts as success.
          if (bus.mult_done) begin
            r_prod <= bus.mult_product;
            r_err  <= 1'b0;
            r_cnt  <= '0;
          end else if (w_tmo) begin
            r_prod <= '0;
            r_err  <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_id      = r_id;
  assign bus.resp_product = r_prod;
  assign bus.resp_err     = r_err;
  assign bus.mult_a       = r_a;
  assign bus.mult_b       = r_b;
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural fixed-latency multiplier.
module tb_mult_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 2*WIDTH+4;
  localparam int LAT     = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] prod;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          grants_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, n_acc = 0;
  int          m_last = NREQ-1;
  int          last_id;
  logic [15:0] last_prod;
  logic        last_err;
  logic        prev_rv = 1'b0;
  logic        hang = 1'b0;
  int          mcnt = 0;
  logic [WIDTH-1:0] opa [NREQ];
  logic [WIDTH-1:0] opb [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last+k) % NREQ]) return (last+k) % NREQ;
    return -1;
  endfunction

  always_comb
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = opa[i];
      bus.req_b[i*WIDTH +: WIDTH] = opb[i];
    end

  always @(posedge clk) cyc++;

  // Multiplier: mult_done is high LAT cycles after the mult_ld cycle.
  always @(negedge clk) begin
    bus.mult_done = 1'b0;
    if (reset) mcnt = 0;
    else if (bus.mult_ld) mcnt = hang ? 0 : LAT;
    else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        bus.mult_done    = 1'b1;
        bus.mult_product = bus.mult_a * bus.mult_b;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_last  = NREQ-1;
      prev_rv = 1'b0;
    end else begin
      if (bus.req_ready != '0) begin
        exp_t e;
        int   eid;
        eid = rr(bus.req_valid, m_last);
        chk("gnt_onehot", bus.req_ready, (eid < 0) ? 0 : (1 << eid));
        chk("gnt_mrdy", bus.mult_ready, 1);
        m_last = eid;
        e.id   = eid;
        e.err  = hang;
        e.prod = hang ? 16'd0 : 16'(opa[eid] * opb[eid]);
        e.cyc  = cyc;
        sb.push_back(e);
        grants_q.push_back(eid);
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) chk("resp_spurious", 1, 0);
        else begin
          exp_t h;
          h = sb[0];
          if (!prev_rv) chk("resp_latency", cyc - h.cyc, h.err ? TIMEOUT+2 : LAT+2);
          chk("resp_id", bus.resp_id, h.id);
          chk("resp_prod", bus.resp_product, h.prod);
          chk("resp_err", bus.resp_err, h.err);
          chk("resp_no_gnt", bus.req_ready, 0);
          chk("resp_no_ld", bus.mult_ld, 0);
          if (bus.resp_ready) begin
            last_id   = bus.resp_id;
            last_prod = bus.resp_product;
            last_err  = bus.resp_err;
            void'(sb.pop_front());
            n_acc++;
          end
        end
      end
      prev_rv = bus.resp_valid && !bus.resp_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    int n = 0;
    while (n_acc < target && n < budget) begin step(1); n++; end
    chk(tag, n_acc, target);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    bus.mult_ready = 1'b1;
    bus.mult_done = 1'b0;
    bus.mult_product = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = WIDTH'($urandom);
      opb[i] = WIDTH'($urandom);
    end
    step(3);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_prod", bus.resp_product, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_mult_ld", bus.mult_ld, 0);
    chk("rst_mult_a", bus.mult_a, 0);
    chk("rst_mult_b", bus.mult_b, 0);
    reset = 1'b0;

    // All four requesters active: strict rotation starting at 0.
    grants_q.delete();
    bus.req_valid = 4'b1111;
    wait_acc(5, 120, "rot_wait");
    bus.req_valid = '0;
    chk("rot_count", grants_q.size(), 5);
    for (int i = 0; i < 5 && i < grants_q.size(); i++)
      chk($sformatf("rot_order%0d", i), grants_q[i], i % NREQ);

    // Directed product on requester 2.
    opa[2] = 8'd200;
    opb[2] = 8'd255;
    bus.req_valid = 4'b0100;
    wait_acc(n_acc + 1, 40, "p2_wait");
    bus.req_valid = '0;
    chk("p2_prod", last_prod, 51000);
    chk("p2_id", last_id, 2);
    chk("p2_err", last_err, 0);

    // Multiplier never completes: watchdog response.
    hang = 1'b1;
    bus.req_valid = 4'b0001;
    wait_acc(n_acc + 1, 60, "tmo_wait");
    bus.req_valid = '0;
    hang = 1'b0;
    chk("tmo_err", last_err, 1);
    chk("tmo_prod", last_prod, 0);

    // Consumer stalls five cycles with all requesters pending.
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    begin
      int n = 0;
      while (!bus.resp_valid && n < 40) begin step(1); n++; end
      chk("stall_seen", bus.resp_valid, 1);
    end
    step(5);
    chk("stall_held", bus.resp_valid, 1);
    bus.resp_ready = 1'b1;
    wait_acc(n_acc + 1, 5, "stall_acc");
    bus.req_valid = '0;
    step(1);
    wait_acc(n_acc + sb.size(), 40, "stall_drain");

    // Reset while BUSY abandons the operation.
    bus.req_valid = 4'b0100;
    step(1);
    bus.req_valid = '0;
    step(4);
    chk("busy_before_rst", bus.mult_ld | bus.resp_valid, 0);
    chk("busy_inflight", sb.size(), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rrst_resp_valid", bus.resp_valid, 0);
    chk("rrst_resp_id", bus.resp_id, 0);
    chk("rrst_resp_prod", bus.resp_product, 0);
    chk("rrst_mult_ld", bus.mult_ld, 0);
    chk("rrst_mult_a", bus.mult_a, 0);
    step(15);
    chk("rrst_no_resp", bus.resp_valid, 0);
    grants_q.delete();
    bus.req_valid = 4'b1111;
    begin
      int n = 0;
      while (grants_q.size() == 0 && n < 10) begin step(1); n++; end
      chk("rrst_gnt_seen", grants_q.size(), 1);
      if (grants_q.size() > 0) chk("rrst_gnt0", grants_q[0], 0);
    end
    bus.req_valid = '0;
    wait_acc(n_acc + sb.size(), 40, "rrst_drain");

    // Multiplier busy: grant appears in the cycle mult_ready rises.
    bus.mult_ready = 1'b0;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrdy_nogrant", bus.req_ready, 0);
      step(1);
    end
    bus.mult_ready = 1'b1;
    @(negedge clk);
    chk("mrdy_grant", bus.req_ready, 4'b0001);
    step(1);
    bus.req_valid = '0;
    wait_acc(n_acc + sb.size(), 40, "mrdy_drain");
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
